// File: rtl/frame_sequencer_pkg.sv
// Shared types and display geometry for the frame sequencer.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FLIP,
        ST_WAIT_ACK
    } seq_state_t;

    localparam int DISP_W = 16;
    localparam int DISP_H = 8;
    localparam int PIXELS = DISP_W * DISP_H;

    typedef logic [3:0] col_t;
    typedef logic [2:0] row_t;
    typedef logic [7:0] color_t;

    // Red ramp shifts one column per acknowledged frame, wrapping mod 16.
    function automatic color_t red_of(input col_t x, input logic [3:0] frame_lsb);
        return {x + frame_lsb, 4'h0};
    endfunction

    function automatic logic last_pixel(input col_t x, input row_t y);
        return (int'(y) * DISP_W + int'(x)) == (PIXELS - 1);
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Pixel-write / buffer-flip bus between the frame sequencer and the display controller.
interface frame_sequencer_if;
    import frame_seq_pkg::*;

    col_t   x;
    row_t   y;
    logic   valid;
    color_t red;
    color_t green;
    color_t blue;
    logic   flip;
    logic   flipped;

    modport master (
        output x, y, valid, red, green, blue, flip,
        input  flipped
    );

    modport slave (
        input  x, y, valid, red, green, blue, flip,
        output flipped
    );

endinterface

// File: rtl/frame_sequencer_tick_gen.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and pulses tick for one cycle on wrap.
module frame_tick_gen #(
    parameter int FRAME_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(FRAME_DIV);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(FRAME_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: on an accepted tick writes one 16x8 frame, requests a flip, then waits for the acknowledge.
// Define FRAME_SEQ_TIMEOUT_EN to add the acknowledge watchdog and the timeout_err port.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int FRAME_DIV      = 1000000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    frame_sequencer_if.master disp,
    output logic              busy,
    output logic [7:0]        frame_count
`ifdef FRAME_SEQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    seq_state_t state;
    logic       tick;
    col_t       next_x;
    row_t       next_y;

    frame_tick_gen #(
        .FRAME_DIV(FRAME_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign busy   = (state != ST_IDLE);
    assign next_x = disp.x + 4'd1;
    assign next_y = (disp.x == 4'(DISP_W - 1)) ? disp.y + 3'd1 : disp.y;

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_count;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // Colours are computed for the pixel being registered so all bus fields stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            disp.x      <= '0;
            disp.y      <= '0;
            disp.valid  <= 1'b0;
            disp.red    <= '0;
            disp.green  <= '0;
            disp.blue   <= '0;
            disp.flip   <= 1'b0;
            frame_count <= '0;
`ifdef FRAME_SEQ_TIMEOUT_EN
            wd_count    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    disp.valid <= 1'b0;
                    disp.flip  <= 1'b0;
                    if (tick && enable) begin
                        state      <= ST_WRITE;
                        disp.valid <= 1'b1;
                        disp.x     <= '0;
                        disp.y     <= '0;
                        disp.red   <= red_of(4'd0, frame_count[3:0]);
                        disp.green <= '0;
                        disp.blue  <= frame_count;
                    end
                end
                ST_WRITE: begin
                    if (last_pixel(disp.x, disp.y)) begin
                        state      <= ST_FLIP;
                        disp.valid <= 1'b0;
                        disp.flip  <= 1'b1;
                    end else begin
                        disp.x     <= next_x;
                        disp.y     <= next_y;
                        disp.red   <= red_of(next_x, frame_count[3:0]);
                        disp.green <= {next_y, 5'b0};
                        disp.blue  <= frame_count;
                    end
                end
                ST_FLIP: begin
                    disp.flip <= 1'b0;
                    state     <= ST_WAIT_ACK;
`ifdef FRAME_SEQ_TIMEOUT_EN
                    wd_count  <= '0;
`endif
                end
                ST_WAIT_ACK: begin
                    if (disp.flipped) begin
                        frame_count <= frame_count + 8'd1;
                        state       <= ST_IDLE;
                    end
`ifdef FRAME_SEQ_TIMEOUT_EN
                    else if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_count <= wd_count + WD_W'(1);
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer (FRAME_DIV=200); define FRAME_SEQ_TIMEOUT_EN to exercise the watchdog path.
module tb_frame_sequencer;

    logic clk;
    logic rst;
    logic enable;
    logic busy;
    logic [7:0] frame_count;
`ifdef FRAME_SEQ_TIMEOUT_EN
    logic timeout_err;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    frame_sequencer_if disp_bus ();

    frame_sequencer #(
        .FRAME_DIV     (200),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .disp       (disp_bus.master),
        .busy       (busy),
        .frame_count(frame_count)
`ifdef FRAME_SEQ_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        int         fc;
        int         pix;
        logic [3:0] x;
        logic [2:0] y;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pix_vec_t;

    pix_vec_t vecs [13];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] bench did not terminate");
    end

    task automatic tick_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic en, input logic ack);
        rst              = r;
        enable           = en;
        disp_bus.flipped = ack;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic wait_for_valid(input int budget, output int at);
        int n;
        n  = 0;
        at = -1;
        while (!disp_bus.valid && n < budget) begin
            tick_cycles(1);
            n++;
        end
        if (disp_bus.valid) at = cyc;
    endtask

    task automatic count_activity(input int n, output int valids, output int flips);
        valids = 0;
        flips  = 0;
        for (int k = 0; k < n; k++) begin
            tick_cycles(1);
            if (disp_bus.valid) valids++;
            if (disp_bus.flip) flips++;
        end
    endtask

    // Walks one frame from pixel 0; flipped is pulsed mid-write and again during FLIP, both must be ignored.
    task automatic scan_frame(input int fc, input int drop_at, input int rst_at);
        for (int i = 0; i < 128; i++) begin
            check_output("pix_valid", disp_bus.valid, 1);
            check_output("pix_x", disp_bus.x, i % 16);
            check_output("pix_y", disp_bus.y, i / 16);
            check_output("pix_red", disp_bus.red, ((i % 16 + fc) % 16) * 16);
            check_output("pix_green", disp_bus.green, (i / 16) * 32);
            check_output("pix_blue", disp_bus.blue, fc);
            for (int k = 0; k < 13; k++) begin
                if (vecs[k].fc == fc && vecs[k].pix == i) begin
                    check_output("vec_x", disp_bus.x, vecs[k].x);
                    check_output("vec_y", disp_bus.y, vecs[k].y);
                    check_output("vec_red", disp_bus.red, vecs[k].red);
                    check_output("vec_green", disp_bus.green, vecs[k].green);
                    check_output("vec_blue", disp_bus.blue, vecs[k].blue);
                end
            end
            disp_bus.flipped = (i == 10);
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                tick_cycles(1);
                return;
            end
            tick_cycles(1);
        end
        check_output("flip_valid_low", disp_bus.valid, 0);
        check_output("flip_high", disp_bus.flip, 1);
        check_output("flip_busy", busy, 1);
        disp_bus.flipped = 1'b1;
        tick_cycles(1);
        disp_bus.flipped = 1'b0;
        check_output("flip_single", disp_bus.flip, 0);
        check_output("wait_busy", busy, 1);
        check_output("flip_ignored_fc", frame_count, fc);
    endtask

    initial begin
        int at;
        int valids;
        int flips;

        vecs[0]  = '{0, 0,   4'd0,  3'd0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{0, 1,   4'd1,  3'd0, 8'h10, 8'h00, 8'h00};
        vecs[2]  = '{0, 15,  4'd15, 3'd0, 8'hF0, 8'h00, 8'h00};
        vecs[3]  = '{0, 16,  4'd0,  3'd1, 8'h00, 8'h20, 8'h00};
        vecs[4]  = '{0, 37,  4'd5,  3'd2, 8'h50, 8'h40, 8'h00};
        vecs[5]  = '{0, 127, 4'd15, 3'd7, 8'hF0, 8'hE0, 8'h00};
        vecs[6]  = '{1, 0,   4'd0,  3'd0, 8'h10, 8'h00, 8'h01};
        vecs[7]  = '{1, 15,  4'd15, 3'd0, 8'h00, 8'h00, 8'h01};
        vecs[8]  = '{1, 127, 4'd15, 3'd7, 8'h00, 8'hE0, 8'h01};
        vecs[9]  = '{2, 14,  4'd14, 3'd0, 8'h00, 8'h00, 8'h02};
        vecs[10] = '{2, 40,  4'd8,  3'd2, 8'hA0, 8'h40, 8'h02};
        vecs[11] = '{2, 127, 4'd15, 3'd7, 8'h10, 8'hE0, 8'h02};
        vecs[12] = '{3, 64,  4'd0,  3'd4, 8'h30, 8'h80, 8'h03};

        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick_cycles(2);
        check_output("rst_valid", disp_bus.valid, 0);
        check_output("rst_flip", disp_bus.flip, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_frame_count", frame_count, 0);
        check_output("rst_x", disp_bus.x, 0);
        check_output("rst_y", disp_bus.y, 0);
        check_output("rst_red", disp_bus.red, 0);
        check_output("rst_green", disp_bus.green, 0);
        check_output("rst_blue", disp_bus.blue, 0);
`ifdef FRAME_SEQ_TIMEOUT_EN
        check_output("rst_timeout_err", timeout_err, 0);
`endif

        apply_stimulus(1'b0, 1'b1, 1'b0);
        cyc = 0;
        wait_for_valid(400, at);
        check_output("first_frame_start", at, 200);
        scan_frame(0, -1, -1);

`ifdef FRAME_SEQ_TIMEOUT_EN
        tick_cycles(49);
        check_output("wd_still_waiting", busy, 1);
        check_output("wd_err_not_yet", timeout_err, 0);
        tick_cycles(1);
        check_output("wd_idle", busy, 0);
        check_output("wd_err_set", timeout_err, 1);
        check_output("wd_frame_count", frame_count, 0);
        tick_cycles(5);
        check_output("wd_err_sticky", timeout_err, 1);
`else
        tick_cycles(4);
        disp_bus.flipped = 1'b1;
        tick_cycles(1);
        disp_bus.flipped = 1'b0;
        check_output("ack_idle", busy, 0);
        check_output("ack_frame_count", frame_count, 1);
        disp_bus.flipped = 1'b1;
        tick_cycles(1);
        disp_bus.flipped = 1'b0;
        tick_cycles(1);
        check_output("idle_flipped_ignored", frame_count, 1);

        wait_for_valid(200, at);
        check_output("second_frame_start", at, 400);
        scan_frame(1, -1, -1);

        count_activity(300, valids, flips);
        check_output("held_ack_no_valid", valids, 0);
        check_output("held_ack_busy", busy, 1);
        check_output("held_ack_fc", frame_count, 1);
        disp_bus.flipped = 1'b1;
        tick_cycles(1);
        disp_bus.flipped = 1'b0;
        check_output("late_ack_fc", frame_count, 2);
        wait_for_valid(400, at);
        check_output("post_ack_frame_start", at, 1000);

        scan_frame(2, 40, -1);
        disp_bus.flipped = 1'b1;
        tick_cycles(1);
        disp_bus.flipped = 1'b0;
        check_output("drop_ack_fc", frame_count, 3);
        check_output("drop_ack_idle", busy, 0);
        count_activity(500, valids, flips);
        check_output("disabled_no_frame", valids, 0);
        check_output("disabled_idle", busy, 0);

        enable = 1'b1;
        wait_for_valid(300, at);
        check_output("reenable_frame_start", at, 1800);
        scan_frame(3, -1, 64);
        check_output("midrst_valid", disp_bus.valid, 0);
        check_output("midrst_flip", disp_bus.flip, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_fc", frame_count, 0);
        check_output("midrst_x", disp_bus.x, 0);
        tick_cycles(1);
        rst = 1'b0;
        count_activity(20, valids, flips);
        check_output("midrst_no_flip", flips, 0);
        check_output("midrst_no_valid", valids, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
